// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: one register write or one register read
// (with repeated START) against a 7-bit slave, open-drain style outputs.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_START  = 4'd1,  S_ADDR_W = 4'd2,  S_ACK1  = 4'd3,
    S_REG    = 4'd4,  S_ACK2   = 4'd5,  S_WDATA  = 4'd6,  S_ACK3  = 4'd7,
    S_RSTART = 4'd8,  S_ADDR_R = 4'd9,  S_ACK4   = 4'd10, S_RDATA = 4'd11,
    S_MNACK  = 4'd12, S_STOP   = 4'd13
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_t      state_r, state_nxt_s, step_s;
  logic [9:0]  div_cnt_r;
  logic [1:0]  qtr_r;
  logic [2:0]  bit_cnt_r;
  logic        rw_r;
  logic [6:0]  dev_r;
  logic [7:0]  reg_r, wdat_r, shift_r, rd_data_r, tx_byte_s;
  logic        busy_r, done_r, ack_err_r, scl_r, sda_r;
  logic        scl_s, sda_s, q_end_s, slot_end_s, sample_s, last_bit_s;
  logic        accept_s, ack_slot_s, byte_slot_s, scl_bit_s;

  assign q_end_s     = (div_cnt_r == DIV_LAST);
  assign slot_end_s  = q_end_s && (qtr_r == 2'd3);
  assign sample_s    = q_end_s && (qtr_r == 2'd2);
  assign last_bit_s  = (bit_cnt_r == 3'd7);
  assign accept_s    = (state_r == S_IDLE) && cmd_valid;
  assign ack_slot_s  = (state_r == S_ACK1) || (state_r == S_ACK2) ||
                       (state_r == S_ACK3) || (state_r == S_ACK4);
  assign byte_slot_s = (state_r == S_ADDR_W) || (state_r == S_REG) ||
                       (state_r == S_WDATA) || (state_r == S_ADDR_R) ||
                       (state_r == S_RDATA);
  assign scl_bit_s   = (qtr_r == 2'd1) || (qtr_r == 2'd2);

  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign rd_data = rd_data_r;
  assign scl_o   = scl_r;
  assign sda_o   = sda_r;

  // Slot sequencing; a NACK recorded during an ack slot diverts to STOP.
  always_comb begin
    step_s = state_r;
    case (state_r)
      S_IDLE:   step_s = S_START;
      S_START:  step_s = S_ADDR_W;
      S_ADDR_W: step_s = last_bit_s ? S_ACK1 : S_ADDR_W;
      S_ACK1:   step_s = ack_err_r ? S_STOP : S_REG;
      S_REG:    step_s = last_bit_s ? S_ACK2 : S_REG;
      S_ACK2: begin
        if (ack_err_r) step_s = S_STOP;
        else if (rw_r) step_s = S_RSTART;
        else           step_s = S_WDATA;
      end
      S_WDATA:  step_s = last_bit_s ? S_ACK3 : S_WDATA;
      S_ACK3:   step_s = S_STOP;
      S_RSTART: step_s = S_ADDR_R;
      S_ADDR_R: step_s = last_bit_s ? S_ACK4 : S_ADDR_R;
      S_ACK4:   step_s = ack_err_r ? S_STOP : S_RDATA;
      S_RDATA:  step_s = last_bit_s ? S_MNACK : S_RDATA;
      S_MNACK:  step_s = S_STOP;
      S_STOP:   step_s = S_IDLE;
      default:  step_s = S_IDLE;
    endcase
    if (accept_s || ((state_r != S_IDLE) && slot_end_s)) state_nxt_s = step_s;
    else                                                 state_nxt_s = state_r;
  end

  // Bus levels for the current slot and quarter.
  always_comb begin
    scl_s = 1'b1;
    sda_s = 1'b1;
    case (state_r)
      S_ADDR_W: tx_byte_s = {dev_r, 1'b0};
      S_REG:    tx_byte_s = reg_r;
      S_WDATA:  tx_byte_s = wdat_r;
      S_ADDR_R: tx_byte_s = {dev_r, 1'b1};
      default:  tx_byte_s = 8'hFF;
    endcase
    case (state_r)
      S_IDLE: begin
        scl_s = 1'b1;
        sda_s = 1'b1;
      end
      S_START: begin
        scl_s = (qtr_r != 2'd3);
        sda_s = (qtr_r == 2'd0);
      end
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
        scl_s = scl_bit_s;
        sda_s = tx_byte_s[3'd7 - bit_cnt_r];
      end
      S_RSTART: begin
        scl_s = scl_bit_s;
        sda_s = (qtr_r == 2'd0) || (qtr_r == 2'd1);
      end
      S_STOP: begin
        scl_s = (qtr_r != 2'd0);
        sda_s = (qtr_r == 2'd2) || (qtr_r == 2'd3);
      end
      default: begin
        scl_s = scl_bit_s;
        sda_s = 1'b1;
      end
    endcase
  end

  // Registered state, timing counters, command latch and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      div_cnt_r <= 10'd0;
      qtr_r     <= 2'd0;
      bit_cnt_r <= 3'd0;
      rw_r      <= 1'b0;
      dev_r     <= 7'd0;
      reg_r     <= 8'd0;
      wdat_r    <= 8'd0;
      shift_r   <= 8'd0;
      rd_data_r <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      sda_r     <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      scl_r   <= scl_s;
      sda_r   <= sda_s;
      done_r  <= (state_r == S_STOP) && slot_end_s;
      if (accept_s) begin
        rw_r      <= cmd_rw;
        dev_r     <= dev_addr;
        reg_r     <= reg_addr;
        wdat_r    <= wr_data;
        busy_r    <= 1'b1;
        ack_err_r <= 1'b0;
        div_cnt_r <= 10'd0;
        qtr_r     <= 2'd0;
        bit_cnt_r <= 3'd0;
      end else if (state_r != S_IDLE) begin
        div_cnt_r <= q_end_s ? 10'd0 : div_cnt_r + 10'd1;
        if (q_end_s) qtr_r <= qtr_r + 2'd1;
        if (slot_end_s && byte_slot_s) bit_cnt_r <= bit_cnt_r + 3'd1;
        if (sample_s && ack_slot_s && sda_i) ack_err_r <= 1'b1;
        if (sample_s && (state_r == S_RDATA)) shift_r <= {shift_r[6:0], sda_i};
        if (slot_end_s && (state_r == S_RDATA) && last_bit_s) rd_data_r <= shift_r;
        if (slot_end_s && (state_r == S_STOP)) busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C slave on the bus.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic       busy, done, ack_err, scl_o, sda_o, sda_i;
  logic [7:0] rd_data;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rw(cmd_rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data),
    .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  // slave configuration (written by the stimulus thread only)
  int         cfg_nack = 0;
  logic       cfg_no_dev = 1'b0;
  logic [7:0] cfg_tx = 8'h5A;
  int         cfg_gen = 0;

  // slave / monitor state
  logic       slv_sda = 1'b1, prev_scl = 1'b1, prev_sda = 1'b1;
  logic       m_ack = 1'b0, m_first = 1'b0, mnack_bit = 1'b0;
  logic [7:0] m_sh = 8'd0;
  int         m_mode = 0, m_bits = 0, m_tx_bits = 0, m_byte = 0, m_gen = -1;
  int         n_start = 0, n_stop = 0;
  logic [7:0] rx_q[$];
  logic       line_sda;

  assign line_sda = sda_o & slv_sda;
  assign sda_i    = line_sda;

  // Bus monitor and slave: detects START/STOP, decodes bytes, drives ACK and read data.
  always @(negedge clk) begin
    prev_scl <= scl_o;
    prev_sda <= line_sda;
    if (scl_o && prev_scl && prev_sda && !line_sda) begin
      n_start <= n_start + 1;
      m_mode  <= 1;
      m_bits  <= 0;
      m_first <= 1'b1;
      slv_sda <= 1'b1;
      if (m_gen != cfg_gen) begin
        m_gen  <= cfg_gen;
        m_byte <= 0;
      end
    end else if (scl_o && prev_scl && !prev_sda && line_sda) begin
      n_stop  <= n_stop + 1;
      m_mode  <= 0;
      slv_sda <= 1'b1;
    end else if (scl_o && !prev_scl) begin
      if (m_mode == 1 && m_bits < 8) begin
        m_sh   <= {m_sh[6:0], line_sda};
        m_bits <= m_bits + 1;
        if (m_bits == 7) rx_q.push_back({m_sh[6:0], line_sda});
      end else if (m_mode == 4) begin
        mnack_bit <= line_sda;
      end
    end else if (!scl_o && prev_scl) begin
      case (m_mode)
        1: if (m_bits == 8) begin
          m_ack   <= !cfg_no_dev && (cfg_nack != m_byte + 1);
          slv_sda <= cfg_no_dev || (cfg_nack == m_byte + 1);
          m_byte  <= m_byte + 1;
          m_mode  <= 2;
        end
        2: begin
          if (m_ack && m_first && m_sh[0]) begin
            m_mode    <= 3;
            slv_sda   <= cfg_tx[7];
            m_tx_bits <= 1;
          end else begin
            m_mode  <= 1;
            slv_sda <= 1'b1;
          end
          m_bits  <= 0;
          m_first <= 1'b0;
        end
        3: if (m_tx_bits == 8) begin
          slv_sda <= 1'b1;
          m_mode  <= 4;
        end else begin
          slv_sda   <= cfg_tx[7 - m_tx_bits];
          m_tx_bits <= m_tx_bits + 1;
        end
        4: m_mode <= 0;
        default: m_mode <= m_mode;
      endcase
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // called at posedge+1; returns at posedge+1 right after the accept edge
  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    cfg_gen   = cfg_gen + 1;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    dev_addr  = dev;
    reg_addr  = ra;
    wr_data   = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 3000 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int base, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b[3];
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    check_eq({tag, "_nbytes"}, 32'(rx_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < rx_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_b[i]));
  endtask

  int lat, base, s0, p0;

  initial begin
    #12;
    check_eq("rst_scl", 32'(scl_o), 32'd1);
    check_eq("rst_sda", 32'(sda_o), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ackerr", 32'(ack_err), 32'd0);
    check_eq("rst_rddata", 32'(rd_data), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 1: write, all ACK
    base = rx_q.size(); s0 = n_start; p0 = n_stop;
    run_cmd(1'b0, 7'h3C, 8'h10, 8'hA5);
    check_eq("wr_busy_rise", 32'(busy), 32'd1);
    wait_done(lat);
    check_eq("wr_latency", 32'(lat), 32'd464);
    check_eq("wr_ackerr", 32'(ack_err), 32'd0);
    check_eq("wr_busy_done", 32'(busy), 32'd0);
    check_bytes("wr", base, 3, 8'h78, 8'h10, 8'hA5);
    check_eq("wr_starts", 32'(n_start - s0), 32'd1);
    check_eq("wr_stops", 32'(n_stop - p0), 32'd1);
    check_eq("wr_rddata_hold", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    check_eq("wr_done_pulse", 32'(done), 32'd0);
    check_eq("idle_scl", 32'(scl_o), 32'd1);
    check_eq("idle_sda", 32'(sda_o), 32'd1);

    // 2: read, all ACK, slave returns 0x5A
    base = rx_q.size(); s0 = n_start; p0 = n_stop;
    run_cmd(1'b1, 7'h3C, 8'h22, 8'h00);
    wait_done(lat);
    check_eq("rd_latency", 32'(lat), 32'd624);
    check_eq("rd_data", 32'(rd_data), 32'h5A);
    check_eq("rd_ackerr", 32'(ack_err), 32'd0);
    check_bytes("rd", base, 3, 8'h78, 8'h22, 8'h79);
    check_eq("rd_starts", 32'(n_start - s0), 32'd2);
    check_eq("rd_stops", 32'(n_stop - p0), 32'd1);
    check_eq("rd_mnack", 32'(mnack_bit), 32'd1);
    @(posedge clk); #1;

    // 3: no device on the bus
    cfg_no_dev = 1'b1;
    base = rx_q.size(); p0 = n_stop;
    run_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done(lat);
    check_eq("nodev_latency", 32'(lat), 32'd176);
    check_eq("nodev_ackerr", 32'(ack_err), 32'd1);
    check_bytes("nodev", base, 1, 8'hA0, 8'h00, 8'h00);
    check_eq("nodev_stops", 32'(n_stop - p0), 32'd1);
    cfg_no_dev = 1'b0;
    @(posedge clk); #1;

    // 4: register byte NACKed on a read
    cfg_nack = 2;
    base = rx_q.size(); s0 = n_start;
    run_cmd(1'b1, 7'h3C, 8'h22, 8'h00);
    check_eq("nack2_ackerr_clr", 32'(ack_err), 32'd0);
    wait_done(lat);
    check_eq("nack2_latency", 32'(lat), 32'd320);
    check_eq("nack2_ackerr", 32'(ack_err), 32'd1);
    check_eq("nack2_starts", 32'(n_start - s0), 32'd1);
    check_eq("nack2_rddata_hold", 32'(rd_data), 32'h5A);
    check_bytes("nack2", base, 2, 8'h78, 8'h22, 8'h00);
    cfg_nack = 0;
    @(posedge clk); #1;

    // 5: cmd_valid mid-transaction is ignored; back-to-back accept in done cycle
    base = rx_q.size();
    run_cmd(1'b0, 7'h3C, 8'h10, 8'hA5);
    fork
      wait_done(lat);
      begin
        repeat (50) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'h99; wr_data = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    join
    check_eq("ign_latency", 32'(lat), 32'd464);
    check_bytes("ign", base, 3, 8'h78, 8'h10, 8'hA5);
    base = rx_q.size();
    run_cmd(1'b0, 7'h3C, 8'h33, 8'h0F);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check_eq("b2b_latency", 32'(lat), 32'd464);
    check_bytes("b2b", base, 3, 8'h78, 8'h33, 8'h0F);
    @(posedge clk); #1;

    // 6: asynchronous reset in the middle of the REG byte
    run_cmd(1'b0, 7'h3C, 8'h10, 8'hA5);
    repeat (199) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_scl", 32'(scl_o), 32'd1);
    check_eq("arst_sda", 32'(sda_o), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rddata", 32'(rd_data), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    base = rx_q.size();
    run_cmd(1'b0, 7'h3C, 8'h10, 8'hA5);
    wait_done(lat);
    check_eq("post_rst_latency", 32'(lat), 32'd464);
    check_eq("post_rst_ackerr", 32'(ack_err), 32'd0);
    check_bytes("post_rst", base, 3, 8'h78, 8'h10, 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-register I2C master that drives the bus opposite the sensor's I2C slave.
- Executes one register write (dev addr+W, reg addr, data) or one register read (dev addr+W, reg addr, repeated START, dev addr+R, one data byte, NACK).
- Sits between the host/test logic and the open-drain SDA/SCL pads. No clock stretching, no multi-master arbitration.

Parameters:
- CLK_DIV, 125, clk cycles per SCL quarter-period (50 MHz / (4*125) = 100 kHz); legal range 2..1023.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- cmd_valid  input  1  request a transaction; accepted when cmd_valid && !busy
- cmd_rw  input  1  0 = write, 1 = read
- dev_addr  input  7  7-bit slave address
- reg_addr  input  8  register address byte
- wr_data  input  8  data byte for writes
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  last transaction saw a NACK on an address/data ack slot
- rd_data  output  8  byte read; valid when done && !ack_err after a read
- scl_o  output  1  1 = release SCL, 0 = drive low
- sda_o  output  1  1 = release SDA, 0 = drive low
- sda_i  input  1  sampled SDA pad level

Behaviour:
- Reset (rst=0, asynchronous): scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, rd_data=0, FSM=IDLE. Reset mid-transaction releases both lines immediately and sends no STOP.
- Accept: in IDLE, cmd_valid=1 latches cmd_rw/dev_addr/reg_addr/wr_data. busy rises next cycle and ack_err clears. cmd_valid while busy is ignored.
- Timing: every bus action is a 4-quarter slot (q0..q3), each quarter CLK_DIV clk cycles, driven by a quarter counter and a bit counter.
- START slot: q0 SCL1/SDA1; q1,q2 SCL1/SDA0; q3 SCL0/SDA0.
- Bit slot (data, or ack driven by master): q0 SCL0/SDA=bit; q1,q2 SCL1; q3 SCL0. SDA is held for the whole slot.
- Receive/ack-sample slot: sda_o=1; sda_i is sampled on the last clk of q2.
- RSTART slot: q0 SCL0/SDA1; q1 SCL1/SDA1; q2 SCL1/SDA0; q3 SCL0/SDA0.
- STOP slot: q0 SCL0/SDA0; q1 SCL1/SDA0; q2,q3 SCL1/SDA1.
- Bytes go out MSB first. Address byte = {dev_addr, R/W}.
- States: IDLE -> START -> ADDR_W (8 bits) -> ACK1 -> REG (8) -> ACK2.
  - Write path: ACK2 -> WDATA (8) -> ACK3 -> STOP -> IDLE.
  - Read path: ACK2 -> RSTART -> ADDR_R (8) -> ACK4 -> RDATA (8 sampled bits) -> MNACK (master drives SDA=1 bit slot) -> STOP -> IDLE.
- Ack sampling: sda_i=1 in ACK1..ACK4 sets ack_err. After that ack slot completes, the FSM goes directly to STOP; no further bytes are sent.
- rd_data loads the shifted byte at the end of the RDATA slot only. It holds its value otherwise, including across write transactions.
- Completion: the cycle after the last STOP clk, done=1 for exactly one cycle, busy=0, and the FSM is in IDLE. A new cmd_valid is accepted in that same cycle.
- Latency, accept-cycle to done, in slots x 4 x CLK_DIV:
  - write, all ACK: 29 slots
  - read, all ACK: 39 slots
  - NACK at ACK1: 11 slots
  - NACK at ACK2: 20 slots
  - NACK at ACK3: 29 slots
  - NACK at ACK4: 30 slots
- Outside a transaction, scl_o=1 and sda_o=1 at all times.

Test Plan:
- CLK_DIV=4, write dev 0x3C, reg 0x10, data 0xA5, bus model ACKs everything -> SDA bytes 0x78, 0x10, 0xA5 decoded on SCL rising edges; START/STOP detected; done at cycle 464 after accept; ack_err=0.
- CLK_DIV=4, read dev 0x3C, reg 0x22, slave model returns 0x5A -> bytes 0x78, 0x22, RSTART, 0x79; master NACK bit = 1; rd_data=0x5A with done at cycle 624; ack_err=0.
- No device on the bus (sda_i held 1), write to dev 0x50 -> ack_err=1; STOP follows the first ack slot; done at cycle 176; 0x10/0xA5 never appear on SDA.
- Slave NACKs the register byte on a read -> ack_err=1; no RSTART; done at 20 slots (320 cycles); rd_data keeps its previous value 0x5A.
- cmd_valid pulsed mid-transaction with different fields -> ignored; the current transaction completes unchanged. A back-to-back cmd_valid in the done cycle is accepted and busy stays high.
- rst asserted in the middle of the REG byte -> scl_o=1, sda_o=1, busy=0 in the same cycle (asynchronous). After release, a fresh write completes normally in 464 cycles.
